shift_unit_pipe: RTL and testbench

//  Parametrised, pipelined multi-mode barrel shifter for the processor execute stage and DSP datapaths.

---
 rtl/shift_unit_pipe.sv | 96 +++++++++
 tb/tb_shift_unit_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined logical/arithmetic barrel shifter with valid/ready handshake and tag pass-through.
// Define SHIFT_UNIT_ROTATE_EN to build ROL/ROR; otherwise ops 100/101 pass the operand through.
module shift_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);
`ifdef SHIFT_UNIT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic             stall;
    logic             v_p  [STAGES+1];
    logic [WIDTH-1:0] d_p  [STAGES+1];
    logic [TAG_W-1:0] t_p  [STAGES+1];
    logic [SHW-1:0]   sh_p [STAGES];
    logic [2:0]       op_p [STAGES];
    logic             sg_p [STAGES];

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign v_p[0]    = in_valid;
    assign d_p[0]    = in_data;
    assign t_p[0]    = in_tag;
    assign sh_p[0]   = in_shamt;
    assign op_p[0]   = in_op;
    assign sg_p[0]   = in_data[WIDTH-1];
    assign out_valid = v_p[STAGES];
    assign out_data  = d_p[STAGES];
    assign out_tag   = t_p[STAGES];

    // Layers are spread MSB-first across the stages as evenly as integer division allows.
    function automatic int stage_of(input int k);
        return (SHW - 1 - k) * STAGES / SHW;
    endfunction

    function automatic logic [WIDTH-1:0] layer(input logic [WIDTH-1:0] d, input logic [2:0] op,
                                               input logic sign, input int k);
        int unsigned      amt;
        logic [WIDTH-1:0] fill;
        amt  = 1 << k;
        fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
        return op == 3'b000 ? d << amt :
               op == 3'b001 ? d >> amt :
               op == 3'b010 ? (d >> amt) | fill :
               ROT_EN && op == 3'b100 ? (d << amt) | (d >> (WIDTH - amt)) :
               ROT_EN && op == 3'b101 ? (d >> amt) | (d << (WIDTH - amt)) : d;
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic             valid_q;
        logic [WIDTH-1:0] data_d, data_q;
        logic [TAG_W-1:0] tag_q;
        always_comb begin
            data_d = d_p[s];
            for (int k = SHW - 1; k >= 0; k--)
                if (stage_of(k) == s && sh_p[s][k]) data_d = layer(data_d, op_p[s], sg_p[s], k);
        end
        always_ff @(posedge clock)
            if (reset) {valid_q, data_q, tag_q} <= '0;
            else if (!stall) {valid_q, data_q, tag_q} <= {v_p[s], data_d, t_p[s]};
        assign {v_p[s+1], d_p[s+1], t_p[s+1]} = {valid_q, data_q, tag_q};
        if (s < STAGES - 1) begin : g_side
            logic [SHW-1:0] sh_q;
            logic [2:0]     op_q;
            logic           sg_q;
            always_ff @(posedge clock)
                if (reset) {sh_q, op_q, sg_q} <= '0;
                else if (!stall) {sh_q, op_q, sg_q} <= {sh_p[s], op_p[s], sg_p[s]};
            assign {sh_p[s+1], op_p[s+1], sg_p[s+1]} = {sh_q, op_q, sg_q};
        end else begin : g_last
            logic zero_q;
            always_ff @(posedge clock)
                if (reset) zero_q <= 1'b0;
                else if (!stall) zero_q <= data_d == '0;
            assign out_zero = zero_q;
        end
    end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: scoreboard bench for shift_unit_pipe (WIDTH=32, STAGES=2, TAG_W=5).
module tb_shift_unit_pipe;
    logic        clock = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, out_zero;
    logic [31:0] in_data = 0, out_data;
    logic [4:0]  in_shamt = 0, in_tag = 0, out_tag;
    logic [2:0]  in_op = 0;
    int          checks = 0, errors = 0, rdy_pct = 100;

    typedef struct {logic [31:0] d; logic [4:0] t;} exp_t;
    exp_t sb[$];

    shift_unit_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_zero(out_zero));

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(logic [31:0] d, int sh, logic [2:0] op);
        logic [63:0] dd;
        dd = {d, d};
        case (op)
            3'b000: return d << sh;
            3'b001: return d >> sh;
            3'b010: return $unsigned($signed(d) >>> sh);
`ifdef SHIFT_UNIT_ROTATE_EN
            3'b100: return dd[63-sh -: 32];
            3'b101: return dd[31+sh -: 32];
`endif
            default: return d;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(logic [31:0] d, int sh, logic [2:0] op, logic [4:0] t);
        int n = 0;
        @(negedge clock);
        in_valid = 1; in_data = d; in_shamt = sh[4:0]; in_op = op; in_tag = t;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clock); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout tag %0d in_ready got 0 expected 1", t);
        end else sb.push_back('{ref_shift(d, sh, op), t});
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clock); n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d expected 0", sb.size());
        end
    endtask

    initial forever begin
        @(negedge clock);
        out_ready = ($urandom_range(99) < rdy_pct);
    end

    // Monitor: pops the scoreboard on every delivered beat and checks stall stability.
    initial begin
        logic        hold;
        logic [31:0] hd;
        logic [4:0]  ht;
        exp_t        e;
        hold = 0; hd = 0; ht = 0;
        forever begin
            @(negedge clock); #2;
            if (reset) hold = 0;
            else begin
                if (hold) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, hd);
                    check("stall_tag", out_tag, ht);
                end
                check("in_ready", in_ready, !(out_valid && !out_ready));
                hold = out_valid && !out_ready; hd = out_data; ht = out_tag;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat tag %0d data %h expected none", out_tag, out_data);
                    end else begin
                        e = sb.pop_front();
                        check("data", out_data, e.d);
                        check("tag", out_tag, e.t);
                        check("zero", out_zero, e.d == 0);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clock);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_tag", out_tag, 0);
        check("rst_zero", out_zero, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clock);
        reset = 0;

        send(32'h0000_0001, 31, 3'b000, 3);
        idle();
        #1 check("lat_early_valid", out_valid, 0);
        @(negedge clock);
        #1;
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 32'h8000_0000);
        check("lat_tag", out_tag, 3);

        send(32'h8000_0000, 4, 3'b010, 5);
        send(32'h8000_0000, 4, 3'b001, 6);
        idle();
        drain();

        rdy_pct = 0;
        repeat (2) @(negedge clock);
        fork
            begin
                for (int t = 1; t <= 4; t++) send($urandom(), $urandom_range(31), 3'b000, t[4:0]);
                idle();
            end
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clock); n++;
                end
                repeat (3) @(negedge clock);
                rdy_pct = 100;
            end
        join
        drain();

        rdy_pct = 0;
        repeat (2) @(negedge clock);
        send(32'hDEAD_BEEF, 3, 3'b001, 11);
        send(32'hCAFE_F00D, 5, 3'b000, 12);
        @(negedge clock);
        in_valid = 0; reset = 1;
        sb.delete();
        @(negedge clock);
        #1;
        check("rst_flight_valid", out_valid, 0);
        check("rst_flight_ready", in_ready, 1);
        reset = 0; rdy_pct = 100;
        repeat (10) @(negedge clock);

        send(32'h8000_0001, 1, 3'b100, 7);
        send(32'h8000_0001, 1, 3'b101, 8);
        send(32'h0000_0000, 7, 3'b011, 9);
        send(32'h1234_5678, 0, 3'b000, 10);
        idle();
        drain();

        rdy_pct = 70;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle();
            send(($urandom_range(7) == 0) ? 32'h0 : $urandom(), $urandom_range(31),
                 3'($urandom_range(7)), 5'($urandom_range(31)));
        end
        idle();
        rdy_pct = 100;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
